// File: rtl/pipe_ctrl.sv
// Central pipeline controller: per-stage stall, global flush/redirect and the
// multi-cycle divide sequencer for the 5-stage core.
module pipe_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VEC    = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rs_rd,
  input  logic        id_rt_rd,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_w_reg_addr,
  input  logic        ex_wd,
  input  logic        ex_div_req,
  input  logic        mem_excp,
  input  logic        mem_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_busy,
  output logic        div_done
);

  typedef enum logic {IDLE, DIV} state_t;

  // The request cycle itself is one stall cycle, so the counter starts one short.
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;

  state_t     state_reg;
  logic [7:0] cnt_reg;

  logic redirect;
  logic load_use;
  logic rs_hit;
  logic rt_hit;

  assign redirect = mem_excp | mem_eret;
  assign rs_hit   = id_rs_rd & (id_rs_addr == ex_w_reg_addr);
  assign rt_hit   = id_rt_rd & (id_rt_addr == ex_w_reg_addr);
  assign load_use = (state_reg == IDLE) & ex_is_load & ex_wd &
                    (ex_w_reg_addr != 5'd0) & (rs_hit | rt_hit);

  assign div_busy = (state_reg == DIV);

  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = 32'd0;
    div_done = 1'b0;
    if (redirect) begin
      flush  = 1'b1;
      new_pc = mem_excp ? EXC_VEC : cp0_epc;
    end else if (state_reg == DIV) begin
      if (cnt_reg != 8'd0) stall = STALL_DIV;
      else                 div_done = 1'b1;
    end else if (ex_div_req) begin
      stall = STALL_DIV;
    end else if (load_use) begin
      stall = STALL_LU;
    end
  end

  // A redirect aborts any divide in flight; the divider result is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else if (redirect) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ex_div_req) begin
            state_reg <= DIV;
            cnt_reg   <= DIV_LOAD;
          end
        end
        DIV: begin
          if (cnt_reg == 8'd0) state_reg <= IDLE;
          else                 cnt_reg   <= cnt_reg - 8'd1;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
        end
      endcase
    end
  end

endmodule
